// File: rtl/int_stim_pkg.sv
// Shared types and constants for the interrupt stimulus generator and its
// companion monitors.
package int_stim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    DELAY  = 2'd2,
    ASSERT = 2'd3
  } state_t;

  localparam logic [1:0] CFG_TARGET = 2'd0;
  localparam logic [1:0] CFG_DELAY  = 2'd1;
  localparam logic [1:0] CFG_CTRL   = 2'd2;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_MODE  = 1;
  localparam int CTRL_REARM = 2;

  localparam logic [31:0] TARGET_PC_RST = 32'h0000_9999;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hffff_fffc;
  endfunction

endpackage

// File: rtl/int_stim_ack_det.sv
// Combinational detector for a store to the interrupt-acknowledge register.
module int_stim_ack_det #(
  parameter logic [31:0] ACK_ADDR = 32'h0000_7f20
) (
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  output logic        ack
);

  assign ack = (|byteen) && ((addr & 32'hffff_fffc) == ACK_ADDR);

endmodule

// File: rtl/int_stim_gen.sv
// Interrupt stimulus source: raises interrupt on a PC match or after a
// programmed delay and holds it until the CPU stores to the ack register.
module int_stim_gen
  import int_stim_pkg::*;
#(
  parameter logic [31:0] ACK_ADDR  = 32'h0000_7f20,
  parameter int          CNT_W     = 16,
  parameter int          MAX_FIRES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      macroscopic_pc,
  input  logic [31:0]      m_int_addr,
  input  logic [3:0]       m_int_byteen,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [31:0]      cfg_wdata,
  output logic             interrupt,
  output logic [CNT_W-1:0] fire_count,
  output logic             busy
);

  state_t           state_r, state_s;
  logic [31:0]      target_pc_r;
  logic [CNT_W-1:0] delay_r;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] fire_count_r, fire_count_s, fire_inc_s;
  logic             mode_r, mode_s, rearm_r, rearm_s;
  logic             interrupt_r, busy_r;
  logic             ack_s, pc_hit_s, ctrl_we_s, abort_s, again_s;

  int_stim_ack_det #(.ACK_ADDR(ACK_ADDR)) u_ack_det (
    .addr   (m_int_addr),
    .byteen (m_int_byteen),
    .ack    (ack_s)
  );

  assign pc_hit_s  = (word_align(macroscopic_pc) == word_align(target_pc_r));
  assign ctrl_we_s = cfg_we && (cfg_sel == CFG_CTRL);
  assign abort_s   = ctrl_we_s && (cfg_wdata[2:0] == 3'b000) && (state_r != IDLE);
  assign fire_inc_s = (fire_count_r == {CNT_W{1'b1}}) ? fire_count_r
                                                      : fire_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
  // Rearm is decided on the post-increment count so MAX_FIRES bounds total fires.
  assign again_s = rearm_r && ((MAX_FIRES == 0) || (int'(fire_inc_s) < MAX_FIRES));

  // Next-state, counter and control-bit logic.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    fire_count_s = fire_count_r;
    mode_s       = mode_r;
    rearm_s      = rearm_r;
    case (state_r)
      IDLE: begin
        if (ctrl_we_s) begin
          mode_s  = cfg_wdata[CTRL_MODE];
          rearm_s = cfg_wdata[CTRL_REARM];
          if (cfg_wdata[CTRL_ARM]) begin
            fire_count_s = {CNT_W{1'b0}};
            cnt_s        = delay_r;
            state_s      = cfg_wdata[CTRL_MODE] ? DELAY : ARMED;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ARMED: begin
        if (pc_hit_s) begin
          state_s = ASSERT;
        end else begin
          state_s = ARMED;
        end
      end
      DELAY: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = ASSERT;
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ASSERT: begin
        if (ack_s) begin
          fire_count_s = fire_inc_s;
          cnt_s        = delay_r;
          if (again_s) begin
            state_s = mode_r ? DELAY : ARMED;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = ASSERT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // A non-arm CTRL write while busy updates mode/rearm; all-zero aborts.
    if (ctrl_we_s && !cfg_wdata[CTRL_ARM] && (state_r != IDLE)) begin
      mode_s  = cfg_wdata[CTRL_MODE];
      rearm_s = cfg_wdata[CTRL_REARM];
    end else begin
      mode_s  = mode_s;
    end
    if (abort_s) begin
      state_s = IDLE;
    end else begin
      state_s = state_s;
    end
  end

  // State, configuration and registered output update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      target_pc_r  <= TARGET_PC_RST;
      delay_r      <= {CNT_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      fire_count_r <= {CNT_W{1'b0}};
      mode_r       <= 1'b0;
      rearm_r      <= 1'b0;
      interrupt_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      fire_count_r <= fire_count_s;
      mode_r       <= mode_s;
      rearm_r      <= rearm_s;
      interrupt_r  <= (state_s == ASSERT);
      busy_r       <= (state_s != IDLE);
      if (cfg_we && (cfg_sel == CFG_TARGET)) begin
        target_pc_r <= cfg_wdata;
      end
      if (cfg_we && (cfg_sel == CFG_DELAY)) begin
        delay_r <= cfg_wdata[CNT_W-1:0];
      end
    end
  end

  assign interrupt  = interrupt_r;
  assign fire_count = fire_count_r;
  assign busy       = busy_r;

endmodule

// File: doc/int_stim_gen.md
Name: int_stim_gen

Overview:
- Synthesizable interrupt stimulus source driving the `interrupt` input of the `mips` top.
- Monitors the CPU's macroscopic PC and its interrupt-acknowledge store. It raises `interrupt` on a programmable PC match or after a programmable cycle delay, and holds it until the CPU acknowledges.
- Used both in bench and on the FPGA build, so one block supplies deterministic, repeatable interrupt injection.

Parameters:
- ACK_ADDR, 32'h0000_7f20, word address of the acknowledge register; compare uses addr & 32'hffff_fffc.
- CNT_W, 16, width of the delay counter and the fire counter.
- MAX_FIRES, 1, fires allowed per arm when rearm is set; 0 means unlimited.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- macroscopic_pc  in  32  CPU macroscopic PC; low 2 bits masked before compare.
- m_int_addr  in  32  CPU data-bus address of the current store.
- m_int_byteen  in  4  CPU store byte enables; any bit set means a store is active.
- cfg_we  in  1  configuration write strobe.
- cfg_sel  in  2  register select: 0 TARGET_PC, 1 DELAY, 2 CTRL.
- cfg_wdata  in  32  configuration write data.
- interrupt  out  1  registered interrupt request to the CPU.
- fire_count  out  CNT_W  fires since reset or arm, saturating at all-ones.
- busy  out  1  high in ARMED, DELAY or ASSERT.

Behaviour:
- Reset (reset==0 at posedge): state IDLE, interrupt=0, fire_count=0, busy=0, TARGET_PC=32'h0000_9999, DELAY=0, CTRL=0.
- CTRL bits:
  - bit0 arm: write-1 pulse, not stored.
  - bit1 mode: 0 = PC match, 1 = delay.
  - bit2 rearm.
- Derived signals:
  - ack = (|m_int_byteen) && ((m_int_addr & 32'hffff_fffc) == ACK_ADDR).
  - pc_hit = ((macroscopic_pc & 32'hffff_fffc) == (TARGET_PC & 32'hffff_fffc)).
- States and transitions:
  - IDLE: on CTRL write with arm=1, clear fire_count. Go to ARMED if mode=0; go to DELAY with cnt=DELAY if mode=1.
  - ARMED: on pc_hit, go to ASSERT next cycle; interrupt=1 from that edge.
  - DELAY: if cnt==0, go to ASSERT; else cnt-=1. DELAY=0 asserts one cycle after arm; DELAY=N asserts N+1 cycles after arm.
  - ASSERT: interrupt held high. On ack, interrupt=0 at the same edge and fire_count+=1 (saturating).
    - If rearm=1 and (MAX_FIRES==0 or new fire_count<MAX_FIRES), go to ARMED or DELAY (reloading cnt) per mode.
    - Otherwise go to IDLE.
- Latency: pc_hit or delay expiry is registered, so interrupt rises exactly one edge after the qualifying cycle.
- An ack seen outside ASSERT is ignored, with no counter change.
- Config writes in non-IDLE states:
  - TARGET_PC and DELAY writes take effect immediately for ARMED compare and for the next reload. A write does not alter an in-flight cnt.
  - CTRL write with arm=0 and mode=rearm=0 is an abort: go to IDLE and drop interrupt.
  - Arm=1 while busy is ignored.
- Simultaneous events:
  - ack and abort in the same cycle: ack is counted first, then the abort forces IDLE.
  - pc_hit and abort in the same cycle: abort wins, no fire.
- pc_hit while PC is stalled on the target: after rearm to ARMED, a still-matching PC refires the next cycle. This is intended.
- Reset mid-operation: full reset state at the next posedge regardless of state; interrupt drops that edge.

Decomposition:
- Shared package `int_stim_pkg`:
  - state enum IDLE/ARMED/DELAY/ASSERT.
  - CFG_TARGET=2'd0, CFG_DELAY=2'd1, CFG_CTRL=2'd2.
  - CTRL bit indices.
  - default TARGET_PC 32'h0000_9999.
- One natural sub-module, `int_stim_ack_det`: combinational ack compare on address and byte enables, parameterized by ACK_ADDR. It is reused by the bridge monitor.

Test Plan:
- PC-match single fire: reset low 2 cycles; write TARGET_PC=32'h3008 and CTRL=3'b001. Drive PC 3000, 3004, 3008.
  -> interrupt=1 one edge after the 3008 cycle.
  -> Store byteen=4'b1111 at addr 32'h7f22 -> interrupt=0 at that edge, fire_count=1, state IDLE.
- Delay mode: DELAY=5, CTRL=3'b011.
  -> interrupt rises exactly 6 edges after the arm write, busy=1 throughout.
  -> Store with byteen=0 at 32'h7f20 does not ack.
- Rearm with MAX_FIRES=2: CTRL=3'b101, PC hits target 3 times, each hit acked.
  -> Exactly 2 fires, fire_count=2, then IDLE; the third hit is ignored.
- Abort collision: in ASSERT, drive a CTRL=0 write and an ack in the same cycle.
  -> fire_count increments, interrupt=0, IDLE.
  -> Same test in ARMED with pc_hit plus abort -> no fire.
- Reset mid-ASSERT: pull reset low for one cycle while interrupt=1.
  -> Next edge: interrupt=0, fire_count=0, TARGET_PC=32'h9999, busy=0.
